// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction per request, with store lane
// alignment and load extraction/extension. Optional build macro: MISALIGN_TRAP_EN.
module lsu #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        func3_i,
    input  logic [DW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    output logic              lsu_busy_o,
    output logic              lsu_valid_o,
    output logic              lsu_err_o,
    output logic [DW-1:0]     rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [DW-1:0] addr_q;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic [CW-1:0] cnt;

    logic          reject;
    logic          trap;
    logic [1:0]    off;
    logic          in_req;
    logic [DW/8-1:0] be;
    logic [DW-1:0] wdata_lane;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 >= 3'b011;
        else
            return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    // Lane offset after rounding the address down to the access size
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [DW-1:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [DW-1:0] d);
        logic [DW-1:0] s;
        s = d >> {o, 3'b000};
        case (f3)
            3'b000:  return {{(DW-8){s[7]}}, s[7:0]};
            3'b001:  return {{(DW-16){s[15]}}, s[15:0]};
            3'b100:  return {{(DW-8){1'b0}}, s[7:0]};
            3'b101:  return {{(DW-16){1'b0}}, s[15:0]};
            default: return d;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    assign trap = is_misaligned(func3_i, addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign reject = is_illegal(lsu_we_i, func3_i) || trap;
    assign off    = lane_off(func3_q, addr_q[1:0]);
    assign in_req = (state == S_REQ);

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << off;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Bus outputs are driven only while a request is outstanding
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & we_q;
    assign mem_be_o    = in_req ? be : '0;
    assign mem_addr_o  = in_req ? {addr_q[AW-1:2], 2'b00} : '0;
    assign mem_wdata_o = in_req ? wdata_lane : '0;

    assign lsu_busy_o  = (state == S_IDLE) ? lsu_req_i : (state != S_DONE);
    assign lsu_valid_o = (state == S_DONE);
    assign lsu_err_o   = (state == S_DONE) & err_q;
    assign rdata_o     = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            func3_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (lsu_req_i) begin
                        addr_q  <= addr_i;
                        we_q    <= lsu_we_i;
                        func3_q <= func3_i;
                        wdata_q <= wdata_i;
                        if (reject) begin
                            state   <= S_DONE;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state <= S_REQ;
                            err_q <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    // rvalid in the grant cycle is ignored; WAIT expects a later one
                    if (mem_gnt_i) begin
                        state <= we_q ? S_DONE : S_WAIT;
                        cnt   <= cnt + 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state   <= S_DONE;
                        rdata_q <= load_ext(func3_q, off, mem_rdata_i);
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_DONE;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: stores, loads, illegal/misaligned access, timeout, reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  func3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        lsu_busy_o, lsu_valid_o, lsu_err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int n_chk = 0;
    int n_fail = 0;

    lsu #(.DW(32), .AW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .func3_i(func3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .lsu_busy_o(lsu_busy_o), .lsu_valid_o(lsu_valid_o), .lsu_err_o(lsu_err_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [38:0] got;
        @(negedge clk);
        got = {lsu_busy_o, lsu_valid_o, lsu_err_o, rdata_o, mem_req_o, mem_we_o, mem_be_o == 4'b0000};
        n_chk++;
        if (got !== {3'b000, 32'h0, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", got, {3'b000, 32'h0, 2'b00, 1'b1});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({lsu_busy_o, lsu_valid_o, mem_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 000", {lsu_busy_o, lsu_valid_o, mem_req_o});
        end
    endtask

    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] ebe,
                            input logic [31:0] ewd, input int gdly);
        logic [70:0] got, exp;
        step;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; func3_i = f3; addr_i = a; wdata_i = d;
        @(negedge clk);
        n_chk++;
        if ({lsu_busy_o, mem_req_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_accept: busy/req got %b want 10", nm, {lsu_busy_o, mem_req_o});
        end
        step;
        lsu_req_i = 1'b0; addr_i = '0; wdata_i = '0;
        exp = {1'b1, 1'b1, ebe, a[31:2], 2'b00, ewd, 1'b1};
        for (int i = 0; i <= gdly; i++) begin
            mem_gnt_i = (i == gdly);
            @(negedge clk);
            got = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, lsu_busy_o};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s_bus%0d: got %h want %h", nm, i, got, exp);
            end
            if (i < gdly) step;
        end
        step;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_err_o, lsu_busy_o, mem_req_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s_done: valid/err/busy/req got %b want 1000", nm,
                     {lsu_valid_o, lsu_err_o, lsu_busy_o, mem_req_o});
        end
    endtask

    // Grant arrives with a junk rvalid that must be ignored; real data comes two cycles later
    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] eaddr,
                           input logic [31:0] exp_d);
        step;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; func3_i = f3; addr_i = a;
        @(negedge clk);
        n_chk++;
        if ({lsu_busy_o, mem_req_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_accept: busy/req got %b want 10", nm, {lsu_busy_o, mem_req_o});
        end
        step;
        lsu_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = ~rd;
        @(negedge clk);
        n_chk++;
        if ({mem_req_o, mem_we_o, mem_addr_o, lsu_busy_o} !== {2'b10, eaddr, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_req: got %h want %h", nm,
                     {mem_req_o, mem_we_o, mem_addr_o, lsu_busy_o}, {2'b10, eaddr, 1'b1});
        end
        step;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({lsu_busy_o, mem_req_o, lsu_valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_wait: busy/req/valid got %b want 100", nm,
                     {lsu_busy_o, mem_req_o, lsu_valid_o});
        end
        step;
        mem_rvalid_i = 1'b1; mem_rdata_i = rd;
        step;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_err_o, lsu_busy_o, rdata_o} !== {3'b100, exp_d}) begin
            n_fail++;
            $display("FAIL %s_done: got %h want %h", nm,
                     {lsu_valid_o, lsu_err_o, lsu_busy_o, rdata_o}, {3'b100, exp_d});
        end
        step;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, rdata_o} !== {1'b0, exp_d}) begin
            n_fail++;
            $display("FAIL %s_hold: got %h want %h", nm, {lsu_valid_o, rdata_o}, {1'b0, exp_d});
        end
    endtask

    task automatic test_stores;
        do_store("sw",  3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0);
        do_store("sb",  3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 2);
        do_store("sh",  3'b001, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 1);
    endtask

    task automatic test_loads;
        do_load("lb",  3'b000, 32'h102, 32'h0080FF00, 32'h100, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h101, 32'h0080FF00, 32'h100, 32'h000000FF);
        do_load("lhu", 3'b101, 32'h102, 32'h80011234, 32'h100, 32'h00008001);
        do_load("lh",  3'b001, 32'h102, 32'h80011234, 32'h100, 32'hFFFF8001);
        do_load("lw",  3'b010, 32'h204, 32'h12345678, 32'h204, 32'h12345678);
    endtask

    task automatic reject_check(input string nm, input logic we, input logic [2:0] f3,
                                input logic [31:0] a);
        step;
        lsu_req_i = 1'b1; lsu_we_i = we; func3_i = f3; addr_i = a;
        step;
        lsu_req_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_err_o, mem_req_o, rdata_o} !== {3'b110, 32'h0}) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm,
                     {lsu_valid_o, lsu_err_o, mem_req_o, rdata_o}, {3'b110, 32'h0});
        end
    endtask

    task automatic test_illegal;
        do_load("pre_illegal_lw", 3'b010, 32'h300, 32'hCAFEF00D, 32'h300, 32'hCAFEF00D);
        reject_check("illegal_load011", 1'b0, 3'b011, 32'h100);
        reject_check("illegal_load110", 1'b0, 3'b110, 32'h100);
        reject_check("illegal_store011", 1'b1, 3'b011, 32'h100);
    endtask

    task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
        reject_check("misalign_lw", 1'b0, 3'b010, 32'h101);
        reject_check("misalign_lh", 1'b0, 3'b001, 32'h103);
`else
        do_load("misalign_lw", 3'b010, 32'h101, 32'hA1B2C3D4, 32'h100, 32'hA1B2C3D4);
        do_load("misalign_lh", 3'b001, 32'h103, 32'h80011234, 32'h100, 32'hFFFF8001);
`endif
    endtask

    task automatic test_timeout;
        int req_cycles;
        do_load("pre_timeout_lw", 3'b010, 32'h400, 32'h55AA55AA, 32'h400, 32'h55AA55AA);
        step;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; func3_i = 3'b010; addr_i = 32'h500;
        step;
        lsu_req_i = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1) req_cycles++;
            if (i < 15) step;
        end
        n_chk++;
        if (req_cycles != 16) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d want 16", req_cycles);
        end
        step;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_err_o, mem_req_o, lsu_busy_o, rdata_o} !== {4'b1100, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_done: got %h want %h",
                     {lsu_valid_o, lsu_err_o, mem_req_o, lsu_busy_o, rdata_o}, {4'b1100, 32'h0});
        end
        step;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_err_o, mem_req_o, lsu_busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_late_resp: got %b want 0000",
                     {lsu_valid_o, lsu_err_o, mem_req_o, lsu_busy_o});
        end
        step;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_busy_o, rdata_o} !== {2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_after: got %h want %h",
                     {lsu_valid_o, lsu_busy_o, rdata_o}, {2'b00, 32'h0});
        end
    endtask

    task automatic test_reset_in_wait;
        step;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; func3_i = 3'b010; addr_i = 32'h600;
        step;
        lsu_req_i = 1'b0; mem_gnt_i = 1'b1;
        step;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if (lsu_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_pre: busy got %b want 1", lsu_busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({mem_req_o, lsu_busy_o, lsu_valid_o, rdata_o} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_wait_async: got %h want %h",
                     {mem_req_o, lsu_busy_o, lsu_valid_o, rdata_o}, {3'b000, 32'h0});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_load("post_reset_lhu", 3'b101, 32'h600, 32'h0000BEEF, 32'h600, 32'h0000BEEF);
    endtask

    task automatic test_back_to_back;
        step;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; func3_i = 3'b010; addr_i = 32'h700;
        wdata_i = 32'h01020304; mem_gnt_i = 1'b1;
        step;
        step;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_busy_o, mem_req_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_done_ignores_req: got %b want 100",
                     {lsu_valid_o, lsu_busy_o, mem_req_o});
        end
        step;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_busy_o, mem_req_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_idle_accept: got %b want 010",
                     {lsu_valid_o, lsu_busy_o, mem_req_o});
        end
        step;
        lsu_req_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({mem_req_o, mem_addr_o, mem_be_o} !== {1'b1, 32'h700, 4'b1111}) begin
            n_fail++;
            $display("FAIL b2b_second_req: got %h want %h",
                     {mem_req_o, mem_addr_o, mem_be_o}, {1'b1, 32'h700, 4'b1111});
        end
        step;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({lsu_valid_o, lsu_err_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_second_done: got %b want 10", {lsu_valid_o, lsu_err_o});
        end
    endtask

    initial begin
        test_reset;
        test_stores;
        test_loads;
        test_illegal;
        test_misalign;
        test_timeout;
        test_reset_in_wait;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
